// File: rtl/ifu_pc_gen.sv
// Instruction-fetch PC generator: owns the PC, fetches one word at a time, hands it to decode, forms the next PC on commit.
// Latency: 4 cycles per instruction minimum (REQ, WAIT, HOLD, EXEC) with zero-wait memory and immediate decode/commit.
// Backpressure: request held until if_req_ready; response waits on if_rsp_valid; instruction held until inst_ready; next fetch waits on commit.
module ifu_pc_gen #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic            pc_src1,
    input  logic            pc_src2,
    input  logic [XLEN-1:0] x_rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_rsp_valid,
    output logic            if_rsp_ready,
    input  logic [31:0]     if_rsp_data,
    input  logic            if_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] off;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] npc;
    logic            npc_misaligned;

    // Next-PC arithmetic: base + offset (silent wrap), JALR clears bit 0, trap target overrides everything.
    always_comb begin
        base = pc_src1 ? x_rs1 : pc;
        off  = pc_src2 ? imm : XLEN'(4);
        sum  = base + off;
        if (pc_src1) begin
            sum[0] = 1'b0;
        end
        npc            = trap_valid ? trap_pc : sum;
        npc_misaligned = |npc[1:0];
    end

    // Handshake strobes decode straight from state; gated by rst so nothing is offered during the reset cycle.
    always_comb begin
        if_req_valid = (state == S_REQ)  && !rst;
        if_rsp_ready = (state == S_WAIT) && !rst;
        if_req_addr  = pc;
    end

    // Fetch FSM with registered decode-side outputs; a misaligned target skips memory and presents a faulting slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            inst        <= 32'd0;
            inst_pc     <= '0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (if_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (if_rsp_valid) begin
                        inst        <= if_rsp_data;
                        inst_pc     <= pc;
                        fetch_fault <= if_rsp_err;
                        inst_valid  <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (commit_valid) begin
                        pc <= npc;
                        if (npc_misaligned) begin
                            inst        <= 32'd0;
                            inst_pc     <= npc;
                            fetch_fault <= 1'b1;
                            inst_valid  <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: doc/ifu_pc_gen.md
Name: ifu_pc_gen

Overview:
- Instruction-fetch front end: owns the architectural PC and consumes the next-PC select signals pc_src1/pc_src2 from the branch condition unit.
- Issues one fetch at a time on a valid/ready instruction-memory interface and presents the fetched word to decode.
- Waits for the core to commit the instruction, then forms the next PC as base + offset, or takes a trap target.
- Single-issue, at most one fetch outstanding. Sits between instruction memory and the decode/execute path of the multicycle core.

Parameters:
- XLEN, 64, datapath/PC width.
- RESET_PC, 64'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- commit_valid  input  1  current instruction finished; next-PC selects are valid this cycle.
- pc_src1  input  1  base select: 0 = PC, 1 = x[rs1].
- pc_src2  input  1  offset select: 0 = 4, 1 = imm.
- x_rs1  input  XLEN  rs1 value for JALR.
- imm  input  XLEN  sign-extended immediate.
- trap_valid  input  1  redirect to trap_pc (ecall/mret); sampled with commit_valid.
- trap_pc  input  XLEN  trap/return target.
- if_req_valid  output  1  fetch request valid.
- if_req_ready  input  1  memory accepts request.
- if_req_addr  output  XLEN  fetch address (= pc).
- if_rsp_valid  input  1  fetch response valid.
- if_rsp_ready  output  1  response accepted.
- if_rsp_data  input  32  instruction word.
- if_rsp_err  input  1  access fault on this response.
- inst_valid  output  1  instruction held for decode.
- inst_ready  input  1  decode consumes instruction.
- inst  output  32  instruction word.
- inst_pc  output  XLEN  PC of inst.
- fetch_fault  output  1  inst carries an access fault or a misaligned-target fault.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - pc = RESET_PC; state = REQ.
  - if_req_valid = 0 and if_rsp_ready = 0 during the reset cycle.
  - inst_valid = 0, inst = 0, inst_pc = 0, fetch_fault = 0.
- First request: if_req_valid rises in the first cycle after rst deasserts.
- FSM states: REQ, WAIT, HOLD, EXEC.
  - REQ: if_req_valid = 1, if_req_addr = pc, both stable until handshake (valid && ready); then go to WAIT.
  - WAIT: if_rsp_ready = 1. On if_rsp_valid, latch inst = if_rsp_data, inst_pc = pc, fetch_fault = if_rsp_err; go to HOLD.
  - HOLD: inst_valid = 1; inst, inst_pc and fetch_fault stable. On inst_ready, go to EXEC with inst_valid = 0 next cycle.
  - EXEC: wait for commit_valid. On commit, update pc and go to REQ. if_req_valid is 1 in the cycle after commit, with the new address.
- Next PC on commit:
  - base = pc_src1 ? x_rs1 : pc; off = pc_src2 ? imm : 4.
  - npc = (base + off) mod 2^XLEN; wrap-around is silent.
  - If pc_src1 = 1, clear npc[0].
  - trap_valid = 1 overrides: npc = trap_pc. Trap wins when both are asserted.
- Misaligned target: if npc[1:0] != 0 (no C extension), do not issue a memory request.
  - Go directly to HOLD with inst = 0, inst_pc = npc, fetch_fault = 1.
  - pc = npc so the trap handler sees the faulting target.
- Ignored inputs:
  - commit_valid and trap_valid are ignored outside EXEC.
  - inst_ready is ignored outside HOLD.
  - if_rsp_valid is ignored outside WAIT (if_rsp_ready = 0 there).
- Minimum loop latency, with zero-wait memory and immediate inst_ready/commit: REQ(1) + WAIT(1) + HOLD(1) + EXEC(1) = 4 cycles per instruction.
- Reset mid-operation: any state returns to REQ with pc = RESET_PC; outstanding request/response is abandoned. Instruction memory shares rst, so no stale response is delivered.
- fetch_fault is not sticky; it is cleared on the next WAIT capture or misaligned-target entry.

Test Plan:
- Reset then sequential fetch: rst 1 cycle; mem returns 0x00000013 with zero wait; commit with pc_src1 = 0, pc_src2 = 0 -> if_req_addr sequence 0x80000000, 0x80000004, 0x80000008; 4 cycles per instruction; inst_pc matches.
- Taken branch/JAL: at pc 0x80000010, commit with pc_src2 = 1, imm = -16 -> next if_req_addr = 0x80000000. With imm = 0x7FC -> 0x8000080C.
- JALR bit0 clear and trap priority: x_rs1 = 0x80001001, imm = 4, pc_src1 = pc_src2 = 1 -> addr 0x80001004. Same cycle trap_valid = 1, trap_pc = 0x80002000 -> addr 0x80002000.
- Handshake stalls: if_req_ready low 3 cycles -> if_req_valid/addr held constant. Response delayed 5 cycles; inst_ready low 2 cycles -> inst/inst_pc stable, no second request issued.
- Faults: if_rsp_err = 1 -> fetch_fault = 1 with inst_pc of the request. JALR target 0x80000002 -> no request issued, inst_valid with fetch_fault = 1, inst_pc = 0x80000002.
- Reset mid-WAIT and wrap: assert rst in WAIT -> next request at 0x80000000. pc = 0xFFFFFFFFFFFFFFFC with +4 -> request at 0x0.
